// File: rtl/poly_unpack_loader_pkg.sv
// Shared definitions for the polynomial unpack loader: Dilithium modulus,
// polynomial geometry, packing-mode codes and the per-mode field width.
package poly_unpack_loader_pkg;

  localparam int RAW_W   = 23;
  localparam int LANE_W  = 24;
  localparam int LANES   = 4;
  localparam int NWORDS  = 64;
  localparam int NCOEFFS = 256;

  localparam logic [RAW_W-1:0] Q = 23'd8380417;

  typedef enum logic [1:0] {
    PACK_RAW23 = 2'd0,
    PACK_T1    = 2'd1,
    PACK_ETA2  = 2'd2,
    PACK_ETA4  = 2'd3
  } pack_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits consumed from the packed stream per coefficient.
  function automatic logic [4:0] pack_width(input pack_mode_e m);
    case (m)
      PACK_RAW23: return 5'd23;
      PACK_T1:    return 5'd10;
      PACK_ETA2:  return 5'd3;
      default:    return 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/poly_unpack_loader_bit_unpacker.sv
// Bit unpacker: 64-bit LSB-first bit buffer with a fill counter. Appends
// 32-bit input words above the valid bits and peels W-bit fields off the
// bottom, one per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      empties the buffer at the start of a load
//   en         extraction allowed (running and coefficients still owed)
//   w          field width for the current mode
//   s_data     input word, appended when accept is high
//   accept     input handshake completed this cycle
//   space_ok   buffer can take another full word (fill <= 32)
//   extract    a field is removed this cycle
//   v_p0       registered extracted field (zero above bit w-1)
//   vld_p0     v_p0 holds a fresh field
module poly_unpack_loader_bit_unpacker
  import poly_unpack_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [4:0]        w,
  input  logic [DATA_W-1:0] s_data,
  input  logic              accept,
  output logic              space_ok,
  output logic              extract,
  output logic [RAW_W-1:0]  v_p0,
  output logic              vld_p0
);

  localparam int BUF_W = 2 * DATA_W;

  logic [BUF_W-1:0] bitbuf;
  logic [BUF_W-1:0] buf_shift;
  logic [BUF_W-1:0] buf_next;
  logic [6:0]       fill;
  logic [6:0]       fill_base;
  logic [6:0]       fill_next;
  logic [RAW_W-1:0] vmask;

  // Bits at and above 'fill' are always zero, so the shifted buffer can be
  // OR-ed with the new word placed at the post-extract fill position.
  assign space_ok  = (fill <= 7'd32);
  assign extract   = en && (fill >= {2'b00, w});
  assign fill_base = fill - (extract ? {2'b00, w} : 7'd0);
  assign buf_shift = extract ? (bitbuf >> w) : bitbuf;
  assign buf_next  = buf_shift |
                     (accept ? ({{DATA_W{1'b0}}, s_data} << fill_base) : '0);
  assign fill_next = fill_base + (accept ? 7'(DATA_W) : 7'd0);
  assign vmask     = ~({RAW_W{1'b1}} << w);

  always_ff @(posedge clk) begin
    if (rst) begin
      bitbuf <= '0;
      fill   <= 7'd0;
      vld_p0 <= 1'b0;
    end else if (clear) begin
      bitbuf <= '0;
      fill   <= 7'd0;
      vld_p0 <= 1'b0;
    end else begin
      bitbuf <= buf_next;
      fill   <= fill_next;
      vld_p0 <= extract;
    end
  end

  // ---- stage p0: extracted field ----
  always_ff @(posedge clk) begin
    if (extract) begin
      v_p0 <= bitbuf[RAW_W-1:0] & vmask;
    end
  end

endmodule

// File: rtl/poly_unpack_loader.sv
// Polynomial unpack loader: consumes a bit-packed coefficient stream
// (RAW23 / T1 / ETA2 / ETA4), maps each coefficient into [0,Q), packs four
// 24-bit lanes per 96-bit word and writes 64 words to the operand BRAM.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, pack_mode   1-cycle load request and packing mode (sampled in IDLE)
//   s_data/s_valid/s_ready   32-bit packed input stream
//   web/addrb/dib      BRAM write port; lane k of dib is coeff 4*addrb+k
//   done               1-cycle pulse after the write to address 63
//   err                sticky range error (RAW23 v>=Q, ETA v>2*eta)
module poly_unpack_loader
  import poly_unpack_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = LANE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              pack_mode,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    web,
  output logic [5:0]              addrb,
  output logic [LANES*COEF_W-1:0] dib,
  output logic                    done,
  output logic                    err
);

  state_e            state;
  pack_mode_e        mode;
  logic [4:0]        w;
  logic [7:0]        budget;
  logic [7:0]        words_in;
  logic [8:0]        coeffs_out;
  logic              load;
  logic              en;
  logic              accept;
  logic              extract;
  logic              space_ok;

  logic [RAW_W-1:0]  v_p0;
  logic              vld_p0;
  logic [COEF_W-1:0] coef_p1;
  logic              vld_p1;
  logic [COEF_W-1:0] lane0_p2;
  logic [COEF_W-1:0] lane1_p2;
  logic [COEF_W-1:0] lane2_p2;
  logic [1:0]        lane_idx;
  logic [5:0]        word_idx;

  // Map a raw field into [0,Q). Out-of-range RAW23 values pass unchanged.
  function automatic logic [COEF_W-1:0] map_coef(input pack_mode_e m,
                                                 input logic [RAW_W-1:0] v);
    logic [RAW_W-1:0] c;
    case (m)
      PACK_RAW23: c = v;
      PACK_T1:    c = {v[9:0], 13'd0};
      PACK_ETA2:  c = (v <= RAW_W'(2)) ? RAW_W'(2) - v : Q + RAW_W'(2) - v;
      default:    c = (v <= RAW_W'(4)) ? RAW_W'(4) - v : Q + RAW_W'(4) - v;
    endcase
    return COEF_W'(c);
  endfunction

  function automatic logic map_bad(input pack_mode_e m,
                                   input logic [RAW_W-1:0] v);
    case (m)
      PACK_RAW23: return v >= Q;
      PACK_T1:    return 1'b0;
      PACK_ETA2:  return v > RAW_W'(4);
      default:    return v > RAW_W'(8);
    endcase
  endfunction

  assign load    = (state == ST_IDLE) && start;
  assign w       = pack_width(mode);
  assign budget  = {w, 3'b000};
  assign en      = (state == ST_RUN) && (coeffs_out < 9'(NCOEFFS));
  // Registers only: the stream must be consumed exactly, 8*W words per load.
  assign s_ready = (state == ST_RUN) && space_ok && (words_in < budget);
  assign accept  = s_valid && s_ready;

  poly_unpack_loader_bit_unpacker #(
    .DATA_W (DATA_W)
  ) u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .clear    (load),
    .en       (en),
    .w        (w),
    .s_data   (s_data),
    .accept   (accept),
    .space_ok (space_ok),
    .extract  (extract),
    .v_p0     (v_p0),
    .vld_p0   (vld_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode       <= PACK_RAW23;
      words_in   <= 8'd0;
      coeffs_out <= 9'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept)  words_in   <= words_in + 8'd1;
      if (extract) coeffs_out <= coeffs_out + 9'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            mode       <= pack_mode_e'(pack_mode);
            words_in   <= 8'd0;
            coeffs_out <= 9'd0;
          end
        end
        ST_RUN: begin
          if (extract && (coeffs_out == 9'(NCOEFFS - 1))) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Pipeline drains; the last word leaves on the address-63 write.
          if (web && (addrb == 6'(NWORDS - 1))) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: coefficient mapping ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      err    <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (load) begin
        err <= 1'b0;
      end else if (vld_p0 && map_bad(mode, v_p0)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) coef_p1 <= map_coef(mode, v_p0);
  end

  // ---- stage p2: lane packing and BRAM write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      web      <= 1'b0;
      addrb    <= 6'd0;
      dib      <= '0;
      lane_idx <= 2'd0;
      word_idx <= 6'd0;
    end else begin
      web <= 1'b0;
      if (load) begin
        lane_idx <= 2'd0;
        word_idx <= 6'd0;
      end else if (vld_p1) begin
        lane_idx <= lane_idx + 2'd1;
        if (lane_idx == 2'd3) begin
          web      <= 1'b1;
          addrb    <= word_idx;
          dib      <= {coef_p1, lane2_p2, lane1_p2, lane0_p2};
          word_idx <= word_idx + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      case (lane_idx)
        2'd0:    lane0_p2 <= coef_p1;
        2'd1:    lane1_p2 <= coef_p1;
        2'd2:    lane2_p2 <= coef_p1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_unpack_loader.sv
module tb_poly_unpack_loader;

  localparam logic [23:0] QV = 24'd8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pack_mode;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        web;
  logic [5:0]  addrb;
  logic [95:0] dib;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] stream [0:183];
  logic [95:0] mem    [0:63];

  // monitor state (written only by the monitor block)
  int   cyc_n       = 0;
  int   wr_cnt      = 0;
  int   exp_addr    = 0;
  int   order_err   = 0;
  int   done_cnt    = 0;
  int   web_cyc63   = -10;
  int   done_cyc    = -20;
  logic err_at_done = 1'b0;

  always #5 clk = ~clk;

  poly_unpack_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pack_mode (pack_mode),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .web       (web),
    .addrb     (addrb),
    .dib       (dib),
    .done      (done),
    .err       (err)
  );

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (web) begin
      if (addrb != exp_addr[5:0]) order_err = order_err + 1;
      mem[addrb] = dib;
      wr_cnt     = wr_cnt + 1;
      exp_addr   = exp_addr + 1;
      if (addrb == 6'd63) web_cyc63 = cyc_n;
    end
    if (done) begin
      done_cnt    = done_cnt + 1;
      done_cyc    = cyc_n;
      err_at_done = err;
    end
    if (done || rst) exp_addr = 0;
  end

  // Reference unpacker: gather field i bit by bit from the packed stream.
  function automatic logic [22:0] ref_v(input int m, input int i);
    int w; int g; logic [22:0] v;
    w = (m == 0) ? 23 : (m == 1) ? 10 : (m == 2) ? 3 : 4;
    v = '0;
    for (int b = 0; b < w; b++) begin
      g = i * w + b;
      v[b] = stream[g / 32][g % 32];
    end
    return v;
  endfunction

  function automatic logic [23:0] ref_coef(input int m, input int i);
    logic [22:0] v; int eta;
    v = ref_v(m, i);
    if (m == 0) return {1'b0, v};
    if (m == 1) return {1'b0, v[9:0], 13'd0};
    eta = (m == 2) ? 2 : 4;
    if (int'(v) <= eta) return 24'(eta - int'(v));
    return QV + 24'(eta) - {1'b0, v};
  endfunction

  function automatic logic ref_err(input int m);
    logic e; logic [22:0] v;
    e = 1'b0;
    for (int i = 0; i < 256; i++) begin
      v = ref_v(m, i);
      if (m == 0 && {1'b0, v} >= QV) e = 1'b1;
      if (m == 2 && v > 23'd4) e = 1'b1;
      if (m == 3 && v > 23'd8) e = 1'b1;
    end
    return e;
  endfunction

  task automatic do_start(input logic [1:0] m);
    @(negedge clk);
    pack_mode = m;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Drive n stream words; after the budget keep s_valid high for 'extra'
  // cycles with junk data. Optionally pulse start at cycle start_at.
  task automatic feed(input int n, input int pct, input int extra,
                      input int start_at, output int accepted);
    int cyc; int post; logic acc;
    accepted = 0; cyc = 0; post = 0;
    while ((accepted < n || post < extra) && cyc < 3000) begin
      start   = (cyc == start_at);
      s_valid = ($urandom_range(0, 99) < pct);
      if (accepted >= n) begin
        s_valid = 1'b1;
        post++;
      end
      s_data = (accepted < n) ? stream[accepted] : 32'hA5A5A5A5;
      acc = s_valid && s_ready;
      @(negedge clk);
      if (acc) accepted++;
      cyc++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    if (cyc >= 3000) begin
      checks++; failures++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", accepted, n);
    end
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (done_cnt == base && k < 600) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (done_cnt == base) begin
      failures++;
      $display("FAIL done_timeout got=no_done required=done");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pack_mode = 2'd0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++; if (web !== 1'b0) begin failures++; $display("FAIL rst_web got=%b exp=0", web); end
    checks++; if (addrb !== 6'd0) begin failures++; $display("FAIL rst_addrb got=%0d exp=0", addrb); end
    checks++; if (dib !== 96'd0) begin failures++; $display("FAIL rst_dib got=%h exp=0", dib); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_t1_ones();
    int acc; int base; int wr0; int ord0; int bad; logic [23:0] got;
    for (int i = 0; i < 80; i++) stream[i] = 32'hFFFFFFFF;
    base = done_cnt; wr0 = wr_cnt; ord0 = order_err;
    do_start(2'd1);
    feed(80, 100, 0, -1, acc);
    wait_done(base);
    checks++; if (acc != 80) begin failures++; $display("FAIL t1_words got=%0d exp=80", acc); end
    checks++; if (wr_cnt - wr0 != 64) begin failures++; $display("FAIL t1_writes got=%0d exp=64", wr_cnt - wr0); end
    checks++; if (order_err != ord0) begin failures++; $display("FAIL t1_addr_order got=%0d exp=0", order_err - ord0); end
    bad = 0; got = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i / 4][24 * (i % 4) +: 24] !== 24'h7FE000) begin
        if (bad == 0) got = mem[i / 4][24 * (i % 4) +: 24];
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL t1_lanes bad=%0d first=%h exp=7fe000", bad, got); end
    checks++; if (done_cyc != web_cyc63 + 1) begin failures++; $display("FAIL t1_done_timing got=%0d exp=%0d", done_cyc, web_cyc63 + 1); end
    checks++; if (done_cnt != base + 1) begin failures++; $display("FAIL t1_done_count got=%0d exp=%0d", done_cnt, base + 1); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL t1_err got=%b exp=0", err); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL t1_idle_ready got=%b exp=0", s_ready); end
  endtask

  task automatic test_eta2_patterns();
    int acc; int base; int bad; logic [23:0] got; int g;
    // all-zero fields map to 2
    for (int i = 0; i < 24; i++) stream[i] = 32'h0;
    base = done_cnt;
    do_start(2'd2);
    feed(24, 100, 0, -1, acc);
    wait_done(base);
    bad = 0; got = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i / 4][24 * (i % 4) +: 24] !== 24'd2) begin
        if (bad == 0) got = mem[i / 4][24 * (i % 4) +: 24];
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL eta2_zero_lanes bad=%0d first=%h exp=000002", bad, got); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL eta2_zero_err got=%b exp=0", err); end
    // every 3-bit field = 3'b100 (v=4) maps to Q-2
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < 32; i++) begin
        g = 32 * j + i;
        stream[j][i] = ((g % 3) == 2);
      end
    end
    base = done_cnt;
    do_start(2'd2);
    feed(24, 100, 0, -1, acc);
    wait_done(base);
    bad = 0; got = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i / 4][24 * (i % 4) +: 24] !== 24'h7FDFFF) begin
        if (bad == 0) got = mem[i / 4][24 * (i % 4) +: 24];
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL eta2_v4_lanes bad=%0d first=%h exp=7fdfff", bad, got); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL eta2_v4_err got=%b exp=0", err); end
  endtask

  task automatic test_raw23_err();
    int acc; int base;
    for (int i = 0; i < 184; i++) stream[i] = 32'h0;
    stream[0] = 32'h007FE001;
    base = done_cnt;
    do_start(2'd0);
    feed(184, 100, 0, -1, acc);
    wait_done(base);
    checks++; if (err_at_done !== 1'b1) begin failures++; $display("FAIL raw_err_at_done got=%b exp=1", err_at_done); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL raw_err_sticky got=%b exp=1", err); end
    checks++; if (mem[0] !== 96'h7FE001) begin failures++; $display("FAIL raw_word0 got=%h exp=7fe001", mem[0]); end
    checks++; if (mem[63] !== 96'h0) begin failures++; $display("FAIL raw_word63 got=%h exp=0", mem[63]); end
  endtask

  task automatic test_rst_mid();
    int acc; int base; int wr0; int ord0; int rdy_hi; int bad; logic [23:0] got; logic [23:0] expv;
    for (int i = 0; i < 184; i++) stream[i] = 32'h9E3779B9 * 32'(i + 1);
    do_start(2'd0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL start_clears_err got=%b exp=0", err); end
    feed(30, 100, 0, -1, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = done_cnt; wr0 = wr_cnt; rdy_hi = 0;
    for (int k = 0; k < 300; k++) begin
      if (s_ready) rdy_hi++;
      @(negedge clk);
    end
    checks++; if (wr_cnt != wr0) begin failures++; $display("FAIL rst_no_web got=%0d exp=0", wr_cnt - wr0); end
    checks++; if (done_cnt != base) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt - base); end
    checks++; if (rdy_hi != 0) begin failures++; $display("FAIL rst_ready got=%0d exp=0", rdy_hi); end
    // fresh load after abort
    base = done_cnt; wr0 = wr_cnt; ord0 = order_err;
    do_start(2'd0);
    feed(184, 100, 0, -1, acc);
    wait_done(base);
    checks++; if (wr_cnt - wr0 != 64) begin failures++; $display("FAIL rst_reload_writes got=%0d exp=64", wr_cnt - wr0); end
    checks++; if (order_err != ord0) begin failures++; $display("FAIL rst_reload_order got=%0d exp=0", order_err - ord0); end
    bad = 0; got = '0; expv = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i / 4][24 * (i % 4) +: 24] !== ref_coef(0, i)) begin
        if (bad == 0) begin got = mem[i / 4][24 * (i % 4) +: 24]; expv = ref_coef(0, i); end
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_reload_data bad=%0d got=%h exp=%h", bad, got, expv); end
    checks++; if (err_at_done !== ref_err(0)) begin failures++; $display("FAIL rst_reload_err got=%b exp=%b", err_at_done, ref_err(0)); end
  endtask

  task automatic test_eta4_random_valid();
    int acc; int base; int wr0; int ord0; int bad; logic [23:0] got; logic [23:0] expv;
    for (int i = 0; i < 32; i++) stream[i] = 32'h01234567 * 32'(i);
    base = done_cnt; wr0 = wr_cnt; ord0 = order_err;
    do_start(2'd3);
    feed(32, 50, 0, -1, acc);
    wait_done(base);
    checks++; if (wr_cnt - wr0 != 64) begin failures++; $display("FAIL eta4_writes got=%0d exp=64", wr_cnt - wr0); end
    checks++; if (order_err != ord0) begin failures++; $display("FAIL eta4_order got=%0d exp=0", order_err - ord0); end
    bad = 0; got = '0; expv = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i / 4][24 * (i % 4) +: 24] !== ref_coef(3, i)) begin
        if (bad == 0) begin got = mem[i / 4][24 * (i % 4) +: 24]; expv = ref_coef(3, i); end
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL eta4_data bad=%0d got=%h exp=%h", bad, got, expv); end
    checks++; if (err !== ref_err(3)) begin failures++; $display("FAIL eta4_err got=%b exp=%b", err, ref_err(3)); end
  endtask

  task automatic test_start_ignored_overrun();
    int acc; int base; int wr0; int bad; logic [23:0] got; logic [23:0] expv;
    for (int i = 0; i < 24; i++) stream[i] = $urandom;
    base = done_cnt; wr0 = wr_cnt;
    do_start(2'd2);
    feed(24, 100, 120, 5, acc);
    wait_done(base);
    repeat (20) @(negedge clk);
    checks++; if (acc != 24) begin failures++; $display("FAIL overrun_words got=%0d exp=24", acc); end
    checks++; if (done_cnt != base + 1) begin failures++; $display("FAIL overrun_done_count got=%0d exp=%0d", done_cnt, base + 1); end
    checks++; if (wr_cnt - wr0 != 64) begin failures++; $display("FAIL overrun_writes got=%0d exp=64", wr_cnt - wr0); end
    bad = 0; got = '0; expv = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i / 4][24 * (i % 4) +: 24] !== ref_coef(2, i)) begin
        if (bad == 0) begin got = mem[i / 4][24 * (i % 4) +: 24]; expv = ref_coef(2, i); end
        bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL overrun_data bad=%0d got=%h exp=%h", bad, got, expv); end
  endtask

  initial begin
    test_reset();
    test_t1_ones();
    test_eta2_patterns();
    test_raw23_err();
    test_rst_mid();
    test_eta4_random_valid();
    test_start_ignored_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
